// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the MemoryUnit CPU-side port.
// Drives the start/busy handshake with a watchdog on a missing busy response.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              init_done_i,
  input  logic              p0_req_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  input  logic              p0_we_i,
  output logic              p0_ack_o,
  input  logic              p1_req_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_we_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] rd_q_o,
  output logic              owner_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_we_o,
  output logic              mem_start_o,
  input  logic              mem_busy_i,
  input  logic [DATA_W-1:0] mem_q_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                start_q, start_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic grant_c;
  logic gnt1_c;
  logic timeout_c;

  // On a tie the port that was not served last wins.
  assign grant_c   = init_done_i & (p0_req_i | p1_req_i);
  assign gnt1_c    = p1_req_i & (~p0_req_i | ~last_q);
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_c) state_d = S_ISSUE;
      S_ISSUE: begin
        if (mem_busy_i)     state_d = S_WAIT;
        else if (timeout_c) state_d = S_DONE;
      end
      S_WAIT:  if (!mem_busy_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    start_d = start_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          owner_d = gnt1_c;
          addr_d  = gnt1_c ? p1_addr_i : p0_addr_i;
          data_d  = gnt1_c ? p1_data_i : p0_data_i;
          we_d    = gnt1_c ? p1_we_i   : p0_we_i;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (!mem_busy_i) begin
          // Watchdog: MemoryUnit never acknowledged start with busy.
          if (timeout_c) begin
            start_d = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!mem_busy_i) begin
          start_d = 1'b0;
          rdata_d = mem_q_i;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          last_d  = owner_q;
        end
      end
      S_DONE:  start_d = 1'b0;
      default: start_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
    end
  end

  assign p0_ack_o    = ack0_q;
  assign p1_ack_o    = ack1_q;
  assign rd_q_o      = rdata_q;
  assign owner_o     = owner_q;
  assign err_o       = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign mem_we_o    = we_q;
  assign mem_start_o = start_q;

endmodule
